piso_shiftreg: RTL and testbench

//  Parallel-in serial-out shift register with a valid/ready load handshake.

---
 rtl/piso_shiftreg.sv | 111 +++++++++++
 tb/tb_piso_shiftreg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_shiftreg.sv
// piso_shiftreg
//   Parallel-in serial-out shift register with a valid/ready load handshake.
//   A WIDTH-bit word is accepted on an edge where load_valid && load_ready and
//   is then emitted one bit per clock on 'out', qualified by 'out_valid', with
//   'done' marking the last bit. A new word may be accepted during the last
//   bit, so consecutive words stream with no gap.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] leaves first; 0: din[0] leaves first
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low
//   load_valid  in   producer has a word on din
//   load_ready  out  word can be accepted on this edge (combinational)
//   din         in   parallel word, sampled only on an accepting edge
//   out         out  serial data bit (registered, 0 when idle)
//   out_valid   out  out carries a word bit this cycle
//   busy        out  a word is being shifted
//   done        out  high while the last bit of a word is on out
module piso_shiftreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_out;
  logic             r_outValid;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;
  logic             w_firstBit;
  logic             w_nextBit;

  // r_cnt is 0 whenever the machine is idle, so the second term only
  // matters during SHIFT, where it opens the handshake on the last bit.
  assign load_ready = (r_state == IDLE) || (r_cnt == LAST);
  assign w_accept   = load_valid && load_ready;

  // r_shreg always holds the bit currently on out at its out end; shifting
  // toward that end exposes the next bit and fills the vacated end with 0.
  assign w_shifted  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
  assign w_firstBit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign w_nextBit  = MSB_FIRST ? w_shifted[WIDTH-1] : w_shifted[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_out      <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_accept) begin
      r_state    <= SHIFT;
      r_shreg    <= din;
      r_cnt      <= '0;
      r_out      <= w_firstBit;
      r_outValid <= 1'b1;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (r_cnt == LAST) begin
        // Last bit went out and nothing new arrived: return to idle.
        r_state    <= IDLE;
        r_shreg    <= '0;
        r_cnt      <= '0;
        r_out      <= 1'b0;
        r_outValid <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt + CW'(1);
        r_out   <= w_nextBit;
        r_done  <= (r_cnt == PRE_LAST);
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_piso_shiftreg.sv
// tb_piso_shiftreg
//   Directed bench for piso_shiftreg. Two instances (MSB-first and LSB-first,
//   WIDTH=4) share the same stimulus; each has its own hand-written expected
//   bit sequence. A small receive-side collector on each serial line
//   reassembles words the way a sipo receiver would.
module tb_piso_shiftreg;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadValid;
  logic [3:0] din;

  logic loadReadyA, outA, outValidA, busyA, doneA;
  logic loadReadyB, outB, outValidB, busyB, doneB;

  logic [3:0] colA;
  logic [3:0] colB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_shiftreg #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (loadValid),
    .load_ready (loadReadyA),
    .din        (din),
    .out        (outA),
    .out_valid  (outValidA),
    .busy       (busyA),
    .done       (doneA)
  );

  piso_shiftreg #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (loadValid),
    .load_ready (loadReadyB),
    .din        (din),
    .out        (outB),
    .out_valid  (outValidB),
    .busy       (busyB),
    .done       (doneB)
  );

  // Receive side: MSB-first bits enter at the bottom, LSB-first at the top,
  // so after a full word each collector equals the word that was sent.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      colA <= 4'b0000;
      colB <= 4'b0000;
    end else begin
      if (outValidA) colA <= {colA[2:0], outA};
      if (outValidB) colB <= {outB, colB[3:1]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag, input logic [3:0] word);
    checkOutput({tag, ".outA"}, outA, 0);
    checkOutput({tag, ".outB"}, outB, 0);
    checkOutput({tag, ".validA"}, outValidA, 0);
    checkOutput({tag, ".validB"}, outValidB, 0);
    checkOutput({tag, ".busyA"}, busyA, 0);
    checkOutput({tag, ".busyB"}, busyB, 0);
    checkOutput({tag, ".doneA"}, doneA, 0);
    checkOutput({tag, ".doneB"}, doneB, 0);
    checkOutput({tag, ".readyA"}, loadReadyA, 1);
    checkOutput({tag, ".readyB"}, loadReadyB, 1);
    checkOutput({tag, ".colA"}, colA, word);
    checkOutput({tag, ".colB"}, colB, word);
  endtask

  // seqA/seqB list the expected serial bits, first bit in position 3.
  task automatic runWord(input string tag, input logic [3:0] word,
                         input logic [3:0] seqA, input logic [3:0] seqB);
    loadValid = 1'b1;
    din       = word;
    stepCycle();
    loadValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s.outA%0d", tag, i), outA, seqA[3-i]);
      checkOutput($sformatf("%s.outB%0d", tag, i), outB, seqB[3-i]);
      checkOutput($sformatf("%s.validA%0d", tag, i), outValidA, 1);
      checkOutput($sformatf("%s.validB%0d", tag, i), outValidB, 1);
      checkOutput($sformatf("%s.busyA%0d", tag, i), busyA, 1);
      checkOutput($sformatf("%s.doneA%0d", tag, i), doneA, (i == 3));
      checkOutput($sformatf("%s.doneB%0d", tag, i), doneB, (i == 3));
      checkOutput($sformatf("%s.readyA%0d", tag, i), loadReadyA, (i == 3));
      if (i < 3) stepCycle();
    end
    stepCycle();
    checkIdle({tag, ".idle"}, word);
  endtask

  logic [7:0] streamA;
  logic [7:0] streamB;

  initial begin
    rst       = 1'b0;
    loadValid = 1'b0;
    din       = 4'b0000;

    // Reset held for two cycles, then released.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstLow.outA", outA, 0);
    checkOutput("rstLow.busyA", busyA, 0);
    rst = 1'b1;
    stepCycle();
    checkIdle("reset", 4'b0000);

    // 1011: MSB-first 1,0,1,1 ; LSB-first 1,1,0,1.
    runWord("w1011", 4'b1011, 4'b1011, 4'b1101);

    // Back-to-back: 1011 then 0110 with load_valid held.
    streamA   = 8'b1011_0110;
    streamB   = 8'b1101_0110;
    loadValid = 1'b1;
    din       = 4'b1011;
    stepCycle();
    din = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) loadValid = 1'b0;
      checkOutput($sformatf("b2b.outA%0d", i), outA, streamA[7-i]);
      checkOutput($sformatf("b2b.outB%0d", i), outB, streamB[7-i]);
      checkOutput($sformatf("b2b.validA%0d", i), outValidA, 1);
      checkOutput($sformatf("b2b.busyB%0d", i), busyB, 1);
      checkOutput($sformatf("b2b.doneA%0d", i), doneA, (i == 3 || i == 7));
      checkOutput($sformatf("b2b.readyA%0d", i), loadReadyA, (i == 3 || i == 7));
      if (i < 7) stepCycle();
    end
    stepCycle();
    checkIdle("b2b.idle", 4'b0110);

    // 1111 in flight; 0000 offered during bit 2 must be ignored.
    loadValid = 1'b1;
    din       = 4'b1111;
    stepCycle();
    loadValid = 1'b0;
    checkOutput("ign.outA0", outA, 1);
    stepCycle();
    loadValid = 1'b1;
    din       = 4'b0000;
    checkOutput("ign.readyA1", loadReadyA, 0);
    checkOutput("ign.readyB1", loadReadyB, 0);
    checkOutput("ign.outA1", outA, 1);
    stepCycle();
    loadValid = 1'b0;
    checkOutput("ign.outA2", outA, 1);
    checkOutput("ign.outB2", outB, 1);
    stepCycle();
    checkOutput("ign.outA3", outA, 1);
    checkOutput("ign.outB3", outB, 1);
    checkOutput("ign.doneA3", doneA, 1);
    stepCycle();
    checkIdle("ign.idle", 4'b1111);

    // Mid-word asynchronous reset after two bits of 1010.
    loadValid = 1'b1;
    din       = 4'b1010;
    stepCycle();
    loadValid = 1'b0;
    checkOutput("arst.outA0", outA, 1);
    checkOutput("arst.outB0", outB, 0);
    stepCycle();
    checkOutput("arst.outA1", outA, 0);
    checkOutput("arst.outB1", outB, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst.validA", outValidA, 0);
    checkOutput("arst.validB", outValidB, 0);
    checkOutput("arst.busyA", busyA, 0);
    checkOutput("arst.busyB", busyB, 0);
    checkOutput("arst.doneA", doneA, 0);
    checkOutput("arst.outB", outB, 0);
    checkOutput("arst.readyA", loadReadyA, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stepCycle();
    checkIdle("arst.idle", 4'b0000);

    // Clean word after reset: MSB-first 0,1,0,1 ; LSB-first 1,0,1,0.
    runWord("w0101", 4'b0101, 4'b0101, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
